// File: rtl/memory_controller_pkg.sv
// Shared widths, size/state encodings and helpers for the RAM sequencer.
package memory_controller_pkg;

    localparam int ADDR_TYPE = 32;
    localparam int INST_TYPE = 32;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Address bits [17:16] selecting the memory-mapped IO window
    localparam logic [1:0] IO_REGION = 2'b11;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/memory_controller_if.sv
// Requester, flush and byte-wide RAM signals of the memory controller.
interface memory_controller_if;
    import memory_controller_pkg::*;

    logic [7:0]           mem_din;
    logic [7:0]           mem_dout;
    logic [ADDR_TYPE-1:0] mem_a;
    logic                 mem_wr;
    logic                 io_buffer_full;

    logic                 if_to_mc_ready;
    logic [ADDR_TYPE-1:0] if_to_mc_PC;
    logic                 mc_to_if_ready;
    logic [INST_TYPE-1:0] mc_to_if_inst;

    logic                 lsb_to_mc_ready;
    logic                 lsb_to_mc_wr;
    logic [1:0]           lsb_to_mc_size;
    logic [ADDR_TYPE-1:0] lsb_to_mc_addr;
    logic [31:0]          lsb_to_mc_data;
    logic                 mc_to_lsb_ready;
    logic [31:0]          mc_to_lsb_data;

    logic                 rob_to_mc_clear;

    modport master (
        output mem_din, io_buffer_full,
        output if_to_mc_ready, if_to_mc_PC,
        output lsb_to_mc_ready, lsb_to_mc_wr, lsb_to_mc_size, lsb_to_mc_addr, lsb_to_mc_data,
        output rob_to_mc_clear,
        input  mem_dout, mem_a, mem_wr,
        input  mc_to_if_ready, mc_to_if_inst, mc_to_lsb_ready, mc_to_lsb_data
    );

    modport slave (
        input  mem_din, io_buffer_full,
        input  if_to_mc_ready, if_to_mc_PC,
        input  lsb_to_mc_ready, lsb_to_mc_wr, lsb_to_mc_size, lsb_to_mc_addr, lsb_to_mc_data,
        input  rob_to_mc_clear,
        output mem_dout, mem_a, mem_wr,
        output mc_to_if_ready, mc_to_if_inst, mc_to_lsb_ready, mc_to_lsb_data
    );

endinterface

// File: rtl/memory_controller.sv
// Arbitrates fetch/LSB onto byte-wide RAM, sequencing 1/2/4-byte little-endian accesses.
// Latency: read done N+1 edges after grant, write done N edges after grant; one-cycle done pulse.
// Backpressure: requests held until done; IO stores stall on io_buffer_full; rdy_in low freezes all state.
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter logic [1:0] IO_ADDR_HI = IO_REGION
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    memory_controller_if.slave  bus
);

    logic [1:0]  state;
    logic [2:0]  cnt;
    logic [2:0]  n_bytes;
    logic [31:0] base;
    logic [31:0] data;
    logic        is_lsb;
    logic        last_grant_lsb;

    logic [7:0]  mem_dout_q;
    logic [31:0] mem_a_q;
    logic        mem_wr_q;
    logic        if_rdy_q;
    logic [31:0] if_inst_q;
    logic        lsb_rdy_q;
    logic [31:0] lsb_dat_q;

    logic        lsb_io_stall;
    logic        req_if;
    logic        req_lsb;
    logic        grant_lsb;
    logic [2:0]  cnt_nxt;
    logic [1:0]  cap_idx;
    logic [31:0] rd_word;

    always_comb begin
        lsb_io_stall = bus.lsb_to_mc_wr && (bus.lsb_to_mc_addr[17:16] == IO_ADDR_HI)
                       && bus.io_buffer_full;
        req_if    = bus.if_to_mc_ready;
        req_lsb   = bus.lsb_to_mc_ready && !lsb_io_stall;
        grant_lsb = req_lsb && (!req_if || !last_grant_lsb);
        cnt_nxt   = cnt + 3'd1;
        // RAM answers one cycle late, so the byte on mem_din belongs to address cnt-1
        cap_idx   = cnt[1:0] - 2'd1;
        rd_word   = data;
        rd_word[{cap_idx, 3'b000} +: 8] = bus.mem_din;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= ST_IDLE;
            cnt            <= 3'd0;
            n_bytes        <= 3'd0;
            base           <= 32'd0;
            data           <= 32'd0;
            is_lsb         <= 1'b0;
            last_grant_lsb <= 1'b0;
            mem_dout_q     <= 8'd0;
            mem_a_q        <= 32'd0;
            mem_wr_q       <= 1'b0;
            if_rdy_q       <= 1'b0;
            if_inst_q      <= 32'd0;
            lsb_rdy_q      <= 1'b0;
            lsb_dat_q      <= 32'd0;
        end else if (rdy_in) begin
            case (state)
                ST_IDLE: begin
                    if (!bus.rob_to_mc_clear && (req_if || req_lsb)) begin
                        is_lsb         <= grant_lsb;
                        last_grant_lsb <= grant_lsb;
                        cnt            <= 3'd0;
                        if (grant_lsb) begin
                            base       <= bus.lsb_to_mc_addr;
                            n_bytes    <= size_bytes(bus.lsb_to_mc_size);
                            data       <= bus.lsb_to_mc_wr ? bus.lsb_to_mc_data : 32'd0;
                            mem_a_q    <= bus.lsb_to_mc_addr;
                            mem_wr_q   <= bus.lsb_to_mc_wr;
                            mem_dout_q <= bus.lsb_to_mc_wr ? bus.lsb_to_mc_data[7:0] : 8'd0;
                            state      <= bus.lsb_to_mc_wr ? ST_WRITE : ST_READ;
                        end else begin
                            base       <= bus.if_to_mc_PC;
                            n_bytes    <= 3'd4;
                            data       <= 32'd0;
                            mem_a_q    <= bus.if_to_mc_PC;
                            mem_wr_q   <= 1'b0;
                            mem_dout_q <= 8'd0;
                            state      <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (bus.rob_to_mc_clear) begin
                        state    <= ST_IDLE;
                        mem_a_q  <= 32'd0;
                        mem_wr_q <= 1'b0;
                    end else begin
                        cnt <= cnt_nxt;
                        if (cnt != 3'd0)
                            data[{cap_idx, 3'b000} +: 8] <= bus.mem_din;
                        mem_a_q <= (cnt_nxt < n_bytes) ? base + {29'd0, cnt_nxt} : 32'd0;
                        if (cnt == n_bytes) begin
                            state <= ST_DONE;
                            if (is_lsb) begin
                                lsb_rdy_q <= 1'b1;
                                lsb_dat_q <= rd_word;
                            end else begin
                                if_rdy_q  <= 1'b1;
                                if_inst_q <= rd_word;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    // A started store always finishes; flush is not looked at here
                    cnt <= cnt_nxt;
                    if (cnt_nxt < n_bytes) begin
                        mem_a_q    <= base + {29'd0, cnt_nxt};
                        mem_dout_q <= data[{cnt_nxt[1:0], 3'b000} +: 8];
                    end else begin
                        mem_a_q    <= 32'd0;
                        mem_wr_q   <= 1'b0;
                        mem_dout_q <= 8'd0;
                        lsb_rdy_q  <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                default: begin
                    if_rdy_q  <= 1'b0;
                    lsb_rdy_q <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_dout        = mem_dout_q;
    assign bus.mem_a           = mem_a_q;
    assign bus.mem_wr          = mem_wr_q;
    assign bus.mc_to_if_ready  = if_rdy_q;
    assign bus.mc_to_if_inst   = if_inst_q;
    assign bus.mc_to_lsb_ready = lsb_rdy_q;
    assign bus.mc_to_lsb_data  = lsb_dat_q;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller with a byte RAM model sharing the rdy_in enable.
module tb_memory_controller;
    import memory_controller_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;
    logic loaded = 1'b0;

    memory_controller_if bus();

    memory_controller #(.IO_ADDR_HI(2'b11)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0] ram [0:65535];

    always @(posedge clk_in) begin
        if (!loaded) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
            ram[16'h1000] <= 8'h13;
            ram[16'h1001] <= 8'h05;
            ram[16'h2001] <= 8'hFE;
            ram[16'h2002] <= 8'hFF;
            ram[16'h2003] <= 8'h77;
            ram[16'h2005] <= 8'h11;
            bus.mem_din   <= 8'h00;
            loaded        <= 1'b1;
        end else if (rdy_in) begin
            if (bus.mem_wr) ram[bus.mem_a[15:0]] <= bus.mem_dout;
            bus.mem_din <= ram[bus.mem_a[15:0]];
        end
    end

    int total = 0;
    int bad   = 0;
    int dbl   = 0;
    logic p_if = 1'b0, p_lsb = 1'b0;

    always @(negedge clk_in) begin
        if (bus.mc_to_if_ready && p_if) dbl++;
        if (bus.mc_to_lsb_ready && p_lsb) dbl++;
        p_if  = bus.mc_to_if_ready;
        p_lsb = bus.mc_to_lsb_ready;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic req_if(input logic [31:0] pc);
        bus.if_to_mc_ready = 1'b1;
        bus.if_to_mc_PC    = pc;
    endtask

    task automatic req_lsb(input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] dat);
        bus.lsb_to_mc_ready = 1'b1;
        bus.lsb_to_mc_wr    = wr;
        bus.lsb_to_mc_size  = size;
        bus.lsb_to_mc_addr  = addr;
        bus.lsb_to_mc_data  = dat;
    endtask

    logic [31:0] a_log [0:15];
    int          wr_cnt;

    task automatic wait_done(input bit lsb, input int clr_at, input int stall_at,
                             output int cyc, output logic [31:0] dat);
        bit got = 0;
        cyc = 0;
        dat = 32'd0;
        wr_cnt = 0;
        while (!got && cyc < 40) begin
            @(negedge clk_in);
            cyc++;
            if (cyc < 16) a_log[cyc] = bus.mem_a;
            if (bus.mem_wr) wr_cnt++;
            bus.rob_to_mc_clear = (cyc == clr_at);
            if (cyc == stall_at) rdy_in = 1'b0;
            if (cyc == stall_at + 3) rdy_in = 1'b1;
            if (lsb ? bus.mc_to_lsb_ready : bus.mc_to_if_ready) begin
                got = 1;
                dat = lsb ? bus.mc_to_lsb_data : bus.mc_to_if_inst;
            end
        end
        bus.rob_to_mc_clear = 1'b0;
        rdy_in = 1'b1;
        if (!got) chk("done_timeout", 32'd0, 32'd1);
    endtask

    int          wr_full;
    logic [31:0] lsb_seen;

    // 1 = IF, 2 = LSB in first/second
    task automatic serve(input int io_rel, output int first, output int second);
        int n = 0;
        bit d_if  = !bus.if_to_mc_ready;
        bit d_lsb = !bus.lsb_to_mc_ready;
        first = 0;
        second = 0;
        wr_full = 0;
        while (!(d_if && d_lsb) && n < 80) begin
            @(negedge clk_in);
            n++;
            if (bus.mem_wr && bus.io_buffer_full) wr_full++;
            if (n == io_rel) bus.io_buffer_full = 1'b0;
            if (bus.mc_to_if_ready) begin
                bus.if_to_mc_ready = 1'b0;
                d_if = 1;
                if (first == 0) first = 1; else second = 1;
            end
            if (bus.mc_to_lsb_ready) begin
                bus.lsb_to_mc_ready = 1'b0;
                lsb_seen = bus.mc_to_lsb_data;
                d_lsb = 1;
                if (first == 0) first = 2; else second = 2;
            end
        end
        if (!(d_if && d_lsb)) chk("serve_timeout", 32'd0, 32'd1);
    endtask

    int          cyc, first, second, cnt;
    logic [31:0] dat;

    initial begin
        bus.io_buffer_full  = 1'b0;
        bus.if_to_mc_ready  = 1'b0;
        bus.if_to_mc_PC     = 32'd0;
        bus.lsb_to_mc_ready = 1'b0;
        bus.lsb_to_mc_wr    = 1'b0;
        bus.lsb_to_mc_size  = SIZE_B;
        bus.lsb_to_mc_addr  = 32'd0;
        bus.lsb_to_mc_data  = 32'd0;
        bus.rob_to_mc_clear = 1'b0;
        #1;
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        chk("rst_mem_a", bus.mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
        chk("rst_rdys", {30'd0, bus.mc_to_if_ready, bus.mc_to_lsb_ready}, 32'd0);
        chk("rst_datas", bus.mc_to_if_inst | bus.mc_to_lsb_data, 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        // word fetch
        req_if(32'h1000);
        wait_done(0, -1, -1, cyc, dat);
        bus.if_to_mc_ready = 1'b0;
        chk("fetch_lat", cyc, 6);
        chk("fetch_inst", dat, 32'h0000_0513);
        for (int k = 0; k < 4; k++) chk("fetch_addr", a_log[k+1], 32'h1000 + k);
        chk("fetch_addr_end", a_log[5], 32'd0);
        @(negedge clk_in);
        chk("fetch_pulse", {31'd0, bus.mc_to_if_ready}, 32'd0);

        // half load, upper bytes zero
        req_lsb(1'b0, SIZE_H, 32'h2001, 32'd0);
        wait_done(1, -1, -1, cyc, dat);
        bus.lsb_to_mc_ready = 1'b0;
        chk("half_lat", cyc, 4);
        chk("half_data", dat, 32'h0000_FFFE);
        @(negedge clk_in);

        // byte store
        req_lsb(1'b1, SIZE_B, 32'h2004, 32'hFFFF_FFAB);
        wait_done(1, -1, -1, cyc, dat);
        bus.lsb_to_mc_ready = 1'b0;
        chk("sb_lat", cyc, 2);
        chk("sb_wr_cycles", wr_cnt, 1);
        chk("sb_addr", a_log[1], 32'h2004);
        @(negedge clk_in);
        chk("sb_ram", {24'd0, ram[16'h2004]}, 32'hAB);
        chk("sb_ram_next", {24'd0, ram[16'h2005]}, 32'h11);

        // round-robin from reset: LSB first, then alternation
        do_reset();
        for (int r = 0; r < 2; r++) begin
            req_if(32'h1000);
            req_lsb(1'b0, SIZE_W, 32'h1000, 32'd0);
            serve(-1, first, second);
            chk("arb_first", first, 2);
            chk("arb_second", second, 1);
            chk("arb_lsb_word", lsb_seen, 32'h0000_0513);
            @(negedge clk_in);
        end

        // IO store stalled while the buffer is full; fetch proceeds
        bus.io_buffer_full = 1'b1;
        req_lsb(1'b1, SIZE_B, 32'h0003_0000, 32'h0000_005A);
        req_if(32'h1000);
        serve(4, first, second);
        chk("io_first", first, 1);
        chk("io_second", second, 2);
        chk("io_wr_while_full", wr_full, 0);
        @(negedge clk_in);
        chk("io_ram", {24'd0, ram[16'h0000]}, 32'h5A);

        // flush at G+2 of a fetch
        req_if(32'h1000);
        cnt = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk_in);
            if (bus.mc_to_if_ready) cnt++;
            if (n == 2) begin
                bus.rob_to_mc_clear = 1'b1;
                bus.if_to_mc_ready  = 1'b0;
            end
            if (n == 3) begin
                bus.rob_to_mc_clear = 1'b0;
                chk("flush_mem_a", bus.mem_a, 32'd0);
                chk("flush_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
            end
        end
        chk("flush_no_done", cnt, 0);
        req_if(32'h1000);
        wait_done(0, -1, -1, cyc, dat);
        bus.if_to_mc_ready = 1'b0;
        chk("flush_refetch_lat", cyc, 6);
        @(negedge clk_in);

        // flush during a word store is ignored
        req_lsb(1'b1, SIZE_W, 32'h2010, 32'hDEAD_BEEF);
        wait_done(1, 2, -1, cyc, dat);
        bus.lsb_to_mc_ready = 1'b0;
        chk("sw_lat", cyc, 5);
        chk("sw_wr_cycles", wr_cnt, 4);
        @(negedge clk_in);
        chk("sw_ram", {ram[16'h2013], ram[16'h2012], ram[16'h2011], ram[16'h2010]}, 32'hDEAD_BEEF);

        // asynchronous reset mid-write
        req_lsb(1'b1, SIZE_W, 32'h2020, 32'h0102_0304);
        repeat (2) @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        chk("arst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("arst_mem_a", bus.mem_a, 32'd0);
        chk("arst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        bus.lsb_to_mc_ready = 1'b0;
        @(negedge clk_in);
        req_if(32'h1000);
        wait_done(0, -1, -1, cyc, dat);
        bus.if_to_mc_ready = 1'b0;
        chk("arst_refetch_lat", cyc, 6);
        @(negedge clk_in);

        // rdy_in low for three cycles mid-read
        req_if(32'h1000);
        wait_done(0, -1, 2, cyc, dat);
        bus.if_to_mc_ready = 1'b0;
        chk("stall_lat", cyc, 9);
        chk("stall_inst", dat, 32'h0000_0513);
        @(negedge clk_in);

        chk("no_double_ready", dbl, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
